// File: rtl/mips150_lsu_if.sv
// Request, memory and load-return bundle for the MIPS150 load-store unit.
// The LSU connects through the slave modport; the driving side uses master.
interface mips150_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [1:0]        MemWrite;
    logic              MemtoReg;
    logic [2:0]        Mask;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              req_ready;
    logic              stall;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_we;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              misalign;

    modport slave (
        input  req_valid, MemWrite, MemtoReg, Mask, addr, wdata,
        output req_ready, stall,
        output mem_valid, mem_addr, mem_we, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output ld_valid, ld_data, misalign
    );

    modport master (
        output req_valid, MemWrite, MemtoReg, Mask, addr, wdata,
        input  req_ready, stall,
        input  mem_valid, mem_addr, mem_we, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  ld_valid, ld_data, misalign
    );
endinterface

// File: rtl/mips150_lsu.sv
// MIPS150 load-store unit: one outstanding access, byte-lane stores, aligned/extended loads.
// Optional alignment trap: define MIPS150_LSU_MISALIGN_TRAP_EN.
module mips150_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mips150_lsu_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    logic              memValid_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [3:0]        memWe_q;
    logic [31:0]       memWdata_q;
    logic              ldValid_q;
    logic [31:0]       ldData_q;
    logic              misalign_q;
    logic              isLoad_q;
    logic [2:0]        mask_q;
    logic [1:0]        addrLo_q;

    logic              isStore;
    logic              isLoad;
    logic              memOp;
    logic              misaligned;
    logic              accept;
    logic [3:0]        memWe_d;
    logic [31:0]       memWdata_d;
    logic [31:0]       ldData_d;

    function automatic logic [31:0] alignLoad(input logic [31:0] rdata,
                                              input logic [2:0]  mask,
                                              input logic [1:0]  lo);
        logic [31:0] shifted;
        logic [7:0]  b;
        logic [15:0] h;
        shifted = rdata >> {lo, 3'b000};
        b       = shifted[7:0];
        h       = lo[1] ? rdata[31:16] : rdata[15:0];
        case (mask)
            3'b000:  alignLoad = {{24{b[7]}}, b};
            3'b001:  alignLoad = {{16{h[15]}}, h};
            3'b011:  alignLoad = {24'h000000, b};
            3'b100:  alignLoad = {16'h0000, h};
            default: alignLoad = rdata;
        endcase
    endfunction

    // Decode the incoming instruction; a nonzero store size wins over a load.
    always_comb begin
        isStore    = (bus.MemWrite != 2'b00);
        isLoad     = bus.MemtoReg && !isStore;
        memOp      = bus.req_valid && (isStore || isLoad);
        memWe_d    = 4'b0000;
        memWdata_d = bus.wdata;
        if (isStore) begin
            case (bus.MemWrite)
                2'b01: begin
                    memWe_d    = 4'b0001 << bus.addr[1:0];
                    memWdata_d = {4{bus.wdata[7:0]}};
                end
                2'b10: begin
                    memWe_d    = bus.addr[1] ? 4'b1100 : 4'b0011;
                    memWdata_d = {2{bus.wdata[15:0]}};
                end
                default: begin
                    memWe_d    = 4'b1111;
                    memWdata_d = bus.wdata;
                end
            endcase
        end
    end

`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (isStore) begin
            case (bus.MemWrite)
                2'b10:   misaligned = bus.addr[0];
                2'b11:   misaligned = (bus.addr[1:0] != 2'b00);
                default: misaligned = 1'b0;
            endcase
        end else if (isLoad) begin
            case (bus.Mask)
                3'b000, 3'b011: misaligned = 1'b0;
                3'b001, 3'b100: misaligned = bus.addr[0];
                default:        misaligned = (bus.addr[1:0] != 2'b00);
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    assign accept   = memOp && (state_q == IDLE) && !misaligned;
    assign ldData_d = alignLoad(bus.mem_rdata, mask_q, addrLo_q);

    // Single-access FSM; mem_rvalid only matters while a load is in REQ or WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            memValid_q <= 1'b0;
            memAddr_q  <= '0;
            memWe_q    <= 4'b0000;
            memWdata_q <= 32'h0;
            ldValid_q  <= 1'b0;
            ldData_q   <= 32'h0;
            misalign_q <= 1'b0;
            isLoad_q   <= 1'b0;
            mask_q     <= 3'b000;
            addrLo_q   <= 2'b00;
        end else begin
            ldValid_q  <= 1'b0;
            misalign_q <= (state_q == IDLE) && memOp && misaligned;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= REQ;
                        memValid_q <= 1'b1;
                        memAddr_q  <= {bus.addr[ADDR_W-1:2], 2'b00};
                        memWe_q    <= memWe_d;
                        memWdata_q <= memWdata_d;
                        isLoad_q   <= isLoad;
                        mask_q     <= bus.Mask;
                        addrLo_q   <= bus.addr[1:0];
                    end
                end
                REQ: begin
                    if (bus.mem_ready) begin
                        memValid_q <= 1'b0;
                        memWe_q    <= 4'b0000;
                        if (!isLoad_q) begin
                            state_q <= IDLE;
                        end else if (bus.mem_rvalid) begin
                            ldData_q  <= ldData_d;
                            ldValid_q <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid) begin
                        ldData_q  <= ldData_d;
                        ldValid_q <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.stall     = rst_n && (accept || (state_q == REQ) || (state_q == WAIT));
    assign bus.mem_valid = memValid_q;
    assign bus.mem_addr  = memAddr_q;
    assign bus.mem_we    = memWe_q;
    assign bus.mem_wdata = memWdata_q;
    assign bus.ld_valid  = ldValid_q;
    assign bus.ld_data   = ldData_q;
    assign bus.misalign  = misalign_q;

endmodule

// File: tb/tb_mips150_lsu.sv
// Scoreboard bench for mips150_lsu: directed accesses push expected memory requests
// and load results; a negedge monitor pops and compares them as the DUT presents them.
module tb_mips150_lsu;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } memExp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic monitorOn = 1'b0;

    memExp_t     memQ[$];
    logic [31:0] ldQ[$];

    always #5 clk = ~clk;

    mips150_lsu_if #(.ADDR_W(32)) bus();

    mips150_lsu #(.ADDR_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Every comparison in the bench funnels through here so the counts stay honest.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'h0, actual}, {31'h0, expected});
    endtask

    task automatic reportUnexpected(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s actual=present required=absent", name);
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard queues.
    always @(negedge clk) begin : monitor
        memExp_t     e;
        logic [31:0] ld;
        if (monitorOn) begin
            if (bus.mem_valid === 1'b1 && bus.mem_ready === 1'b1) begin
                if (memQ.size() == 0) begin
                    reportUnexpected("mem_request");
                end else begin
                    e = memQ.pop_front();
                    checkOutput("mem_addr", bus.mem_addr, e.addr);
                    checkOutput("mem_we", {28'h0, bus.mem_we}, {28'h0, e.we});
                    if (e.we != 4'b0000) checkOutput("mem_wdata", bus.mem_wdata, e.wdata);
                end
            end
            if (bus.ld_valid !== 1'b0) begin
                if (ldQ.size() == 0) begin
                    reportUnexpected("ld_valid");
                end else begin
                    ld = ldQ.pop_front();
                    checkOutput("ld_data", bus.ld_data, ld);
                end
            end
        end
    end

    // One complete access. rvalidDelay < 0 returns load data in the handshake cycle,
    // otherwise after that many idle WAIT cycles.
    task automatic applyStimulus(input logic [1:0] mw, input logic mtr, input logic [2:0] mask,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input int readyDelay, input int rvalidDelay,
                                 input logic [31:0] rdata, input logic [31:0] expAddr,
                                 input logic [3:0] expWe, input logic [31:0] expWdata,
                                 input logic [31:0] expLd);
        memExp_t e;
        logic    isLd;
        isLd    = (mw == 2'b00) && mtr;
        e.addr  = expAddr;
        e.we    = expWe;
        e.wdata = expWdata;
        memQ.push_back(e);
        if (isLd) ldQ.push_back(expLd);

        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.MemWrite  = mw;
        bus.MemtoReg  = mtr;
        bus.Mask      = mask;
        bus.addr      = a;
        bus.wdata     = wd;
        @(negedge clk);
        checkBit("accept_req_ready", bus.req_ready, 1'b1);
        checkBit("accept_stall", bus.stall, 1'b1);

        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b0;
        for (int k = 0; k < readyDelay; k++) begin
            @(negedge clk);
            checkBit("hold_mem_valid", bus.mem_valid, 1'b1);
            checkOutput("hold_mem_addr", bus.mem_addr, expAddr);
            checkOutput("hold_mem_we", {28'h0, bus.mem_we}, {28'h0, expWe});
            checkBit("hold_req_ready", bus.req_ready, 1'b0);
            checkBit("hold_stall", bus.stall, 1'b1);
            @(posedge clk); #1;
        end
        bus.mem_ready = 1'b1;
        if (isLd && rvalidDelay < 0) begin
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
        end
        @(posedge clk); #1;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;

        if (!isLd) begin
            @(negedge clk);
            checkBit("store_back_idle", bus.req_ready, 1'b1);
            checkBit("store_mem_valid_low", bus.mem_valid, 1'b0);
        end else begin
            if (rvalidDelay >= 0) begin
                for (int k = 0; k < rvalidDelay; k++) begin
                    @(negedge clk);
                    checkBit("wait_stall", bus.stall, 1'b1);
                    checkBit("wait_ld_valid", bus.ld_valid, 1'b0);
                    checkBit("wait_mem_valid", bus.mem_valid, 1'b0);
                    @(posedge clk); #1;
                end
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = rdata;
                @(posedge clk); #1;
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = 32'h0;
            end
            @(negedge clk);
            checkBit("done_stall", bus.stall, 1'b0);
            checkBit("done_req_ready", bus.req_ready, 1'b0);
            checkBit("done_ld_valid", bus.ld_valid, 1'b1);
            @(posedge clk); #1;
            @(negedge clk);
            checkBit("after_done_ld_valid", bus.ld_valid, 1'b0);
            checkOutput("ld_data_hold", bus.ld_data, expLd);
            checkBit("after_done_idle", bus.req_ready, 1'b1);
        end
    endtask

`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
    task automatic checkMisalign(input logic [1:0] mw, input logic mtr, input logic [2:0] mask,
                                 input logic [31:0] a);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.MemWrite  = mw;
        bus.MemtoReg  = mtr;
        bus.Mask      = mask;
        bus.addr      = a;
        bus.wdata     = 32'h0;
        @(negedge clk);
        checkBit("trap_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        checkBit("trap_misalign", bus.misalign, 1'b1);
        checkBit("trap_mem_valid", bus.mem_valid, 1'b0);
        checkBit("trap_req_ready", bus.req_ready, 1'b1);
        checkBit("trap_ld_valid", bus.ld_valid, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        checkBit("trap_pulse_end", bus.misalign, 1'b0);
    endtask
`endif

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.MemWrite   = 2'b00;
        bus.MemtoReg   = 1'b0;
        bus.Mask       = 3'b000;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkBit("rst_req_ready", bus.req_ready, 1'b1);
        checkBit("rst_stall", bus.stall, 1'b0);
        checkBit("rst_mem_valid", bus.mem_valid, 1'b0);
        checkOutput("rst_mem_we", {28'h0, bus.mem_we}, 32'h0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
        checkBit("rst_ld_valid", bus.ld_valid, 1'b0);
        checkOutput("rst_ld_data", bus.ld_data, 32'h0);
        checkBit("rst_misalign", bus.misalign, 1'b0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        monitorOn = 1'b1;

        $display("[TB] directed store/load vectors");
        applyStimulus(2'b01, 1'b0, 3'b000, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0,
                      32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0);
        applyStimulus(2'b00, 1'b1, 3'b000, 32'h0000_2001, 32'h0, 0, 3, 32'h0000_F000,
                      32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_FFF0);
        applyStimulus(2'b00, 1'b1, 3'b011, 32'h0000_2001, 32'h0, 0, 3, 32'h0000_F000,
                      32'h0000_2000, 4'b0000, 32'h0, 32'h0000_00F0);
        applyStimulus(2'b00, 1'b1, 3'b100, 32'h0000_2002, 32'h0, 0, -1, 32'h8001_FFFF,
                      32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001);
        applyStimulus(2'b10, 1'b0, 3'b000, 32'h0000_4002, 32'h1234_ABCD, 5, 0, 32'h0,
                      32'h0000_4000, 4'b1100, 32'hABCD_ABCD, 32'h0);
        applyStimulus(2'b00, 1'b1, 3'b001, 32'h0000_2002, 32'h0, 2, -1, 32'h8001_FFFF,
                      32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8001);
        applyStimulus(2'b00, 1'b1, 3'b010, 32'h0000_5000, 32'h0, 1, 1, 32'hDEAD_BEEF,
                      32'h0000_5000, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        applyStimulus(2'b00, 1'b1, 3'b110, 32'h0000_5004, 32'h0, 0, 0, 32'h1234_5678,
                      32'h0000_5004, 4'b0000, 32'h0, 32'h1234_5678);
        applyStimulus(2'b11, 1'b1, 3'b000, 32'h0000_6000, 32'hCAFE_F00D, 0, 0, 32'h0,
                      32'h0000_6000, 4'b1111, 32'hCAFE_F00D, 32'h0);
        applyStimulus(2'b00, 1'b1, 3'b000, 32'h0000_2003, 32'h0, 0, 0, 32'h7F00_0000,
                      32'h0000_2000, 4'b0000, 32'h0, 32'h0000_007F);
        applyStimulus(2'b00, 1'b1, 3'b001, 32'h0000_2000, 32'h0, 0, -1, 32'h0000_8000,
                      32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8000);
        applyStimulus(2'b01, 1'b0, 3'b000, 32'h0000_1001, 32'h0000_0055, 0, 0, 32'h0,
                      32'h0000_1000, 4'b0010, 32'h5555_5555, 32'h0);
        applyStimulus(2'b10, 1'b0, 3'b000, 32'h0000_4000, 32'h0000_BEEF, 0, 0, 32'h0,
                      32'h0000_4000, 4'b0011, 32'hBEEF_BEEF, 32'h0);

        $display("[TB] non-memory instruction and stray mem_rvalid");
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.MemWrite  = 2'b00;
        bus.MemtoReg  = 1'b0;
        @(negedge clk);
        checkBit("nonmem_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hFFFF_FFFF;
        @(negedge clk);
        checkBit("nonmem_mem_valid", bus.mem_valid, 1'b0);
        checkBit("nonmem_req_ready", bus.req_ready, 1'b1);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        checkBit("idle_rvalid_ignored", bus.ld_valid, 1'b0);

        $display("[TB] reset while waiting for load data");
        begin
            memExp_t e;
            e.addr  = 32'h0000_2000;
            e.we    = 4'b0000;
            e.wdata = 32'h0;
            memQ.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.MemWrite  = 2'b00;
        bus.MemtoReg  = 1'b1;
        bus.Mask      = 3'b000;
        bus.addr      = 32'h0000_2001;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checkBit("pre_reset_wait_stall", bus.stall, 1'b1);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0000_F000;
        @(negedge clk);
        checkBit("abort_idle", bus.req_ready, 1'b1);
        checkBit("abort_stall", bus.stall, 1'b0);
        @(posedge clk); #1;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        checkBit("abort_no_ld_valid", bus.ld_valid, 1'b0);

`ifdef MIPS150_LSU_MISALIGN_TRAP_EN
        $display("[TB] misaligned accesses trap");
        checkMisalign(2'b11, 1'b0, 3'b000, 32'h0000_3002);
        checkMisalign(2'b00, 1'b1, 3'b001, 32'h0000_2001);
        checkMisalign(2'b00, 1'b1, 3'b111, 32'h0000_5002);
`else
        $display("[TB] misaligned accesses issue aligned");
        applyStimulus(2'b11, 1'b0, 3'b000, 32'h0000_3002, 32'h89AB_CDEF, 0, 0, 32'h0,
                      32'h0000_3000, 4'b1111, 32'h89AB_CDEF, 32'h0);
        applyStimulus(2'b00, 1'b1, 3'b001, 32'h0000_2003, 32'h0, 0, -1, 32'h8001_FFFF,
                      32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8001);
        @(negedge clk);
        checkBit("misalign_tied_low", bus.misalign, 1'b0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("memQ_drained", memQ.size(), 32'd0);
        checkOutput("ldQ_drained", ldQ.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips150_lsu.md
MIPS150_LSU -- requirements
Module: mips150_lsu

Interface
REQ-001 Parameter: ADDR_W, 32, width of addr and mem_addr.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 req_valid  in  1  decode stage presents an instruction this cycle.
REQ-005 MemWrite  in  2  store size from control decode: 00 none, 01 SB, 10 SH, 11 SW.
REQ-006 MemtoReg  in  1  instruction is a load.
REQ-007 Mask  in  3  load type: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU.
REQ-008 addr  in  ADDR_W  effective byte address from ALU.
REQ-009 wdata  in  32  store data, rt value.
REQ-010 req_ready  out  1  LSU idle and able to accept.
REQ-011 stall  out  1  hold upstream pipeline.
REQ-012 mem_valid, mem_addr[ADDR_W], mem_we[4], mem_wdata[32]  out  memory request channel; mem_we all-zero means read.
REQ-013 mem_ready  in  1  memory accepts request.
REQ-014 mem_rvalid, mem_rdata[32]  in  load return.
REQ-015 ld_valid, ld_data[32]  out  aligned, extended load result.
REQ-016 misalign  out  1  misaligned-access trap pulse.

Function
REQ-017 Mem op = req_valid and (MemWrite != 00 or MemtoReg); MemWrite != 00 SHALL take priority over MemtoReg.
REQ-018 FSM states IDLE, REQ, WAIT, DONE; req_ready = (state == IDLE).
REQ-019 IDLE: mem op accepted -> latch addr, wdata, MemWrite, Mask -> REQ; otherwise stay.
REQ-020 REQ: mem_valid=1, fields held stable until mem_ready=1; store + mem_ready -> IDLE; load + mem_ready -> WAIT, or DONE if mem_rvalid=1 in the same cycle.
REQ-021 WAIT: mem_rvalid=1 -> capture mem_rdata -> DONE.
REQ-022 DONE: ld_valid=1 for exactly one cycle -> IDLE; no new request accepted in DONE.
REQ-023 stall = 1 in the accepting IDLE cycle and in REQ and WAIT; stall = 0 in DONE.
REQ-024 mem_addr = {addr[ADDR_W-1:2], 2'b00}; byte lane i = bits [8i+7:8i].
REQ-025 SB: mem_we = 0001 << addr[1:0]; mem_wdata = {4{wdata[7:0]}}.
REQ-026 SH: mem_we = addr[1] ? 1100 : 0011; mem_wdata = {2{wdata[15:0]}}.
REQ-027 SW: mem_we = 1111; mem_wdata = wdata.
REQ-028 Loads: byte selected by addr[1:0], half by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
REQ-029 Mask 101..111 on a load SHALL be treated as LW.
REQ-030 mem_rvalid outside WAIT/REQ SHALL be ignored.
REQ-031 ld_data SHALL hold its last value when ld_valid=0.

Reset
REQ-032 rst_n=0 at a clock edge SHALL force state IDLE, and mem_valid, mem_we, ld_valid, misalign, stall to 0, and mem_addr, mem_wdata, ld_data to 0.
REQ-033 Reset mid-transaction SHALL abandon the access; a later mem_rvalid SHALL be ignored.

Configuration
REQ-034 Macro MIPS150_LSU_MISALIGN_TRAP_EN.
REQ-035 Defined: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=00, SHALL not be issued; misalign pulses 1 cycle, state stays IDLE, stall=0, ld_valid=0.
REQ-036 Undefined: misalign is tied 0; halfword ops ignore addr[0], word ops ignore addr[1:0].

Verification
REQ-037 SB addr=0x1003 wdata=0x000000AB, mem_ready=1 -> mem_addr=0x1000, mem_we=1000, mem_wdata=0xABABABAB, back to IDLE after 1 cycle.
REQ-038 LB addr=0x2001, rdata=0x0000F000 after 3 wait cycles -> ld_valid for one cycle, ld_data=0xFFFFFFF0; LBU same -> 0x000000F0; stall high throughout, low in DONE.
REQ-039 LHU addr=0x2002, mem_ready and mem_rvalid in the same cycle, rdata=0x8001FFFF -> REQ->DONE directly, ld_data=0x00008001.
REQ-040 mem_ready held low for 5 cycles -> mem_valid, mem_addr, mem_we stable each cycle; req_ready=0.
REQ-041 rst_n=0 while in WAIT, then mem_rvalid=1 -> no ld_valid; state IDLE.
REQ-042 SW addr=0x3002: with macro -> misalign=1 one cycle, mem_valid=0; without -> mem_we=1111, mem_addr=0x3000.
